// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: round count, controller state encoding,
// the 4-bit S-box, the bit permutation layer and the key-schedule update.
package present_pkg;

  localparam int ROUNDS = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Bit j moves to (16*j) mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] p;
    p = '0;
    p[63] = s[63];
    for (int j = 0; j < 63; j++) begin
      p[(16 * j) % 63] = s[j];
    end
    return p;
  endfunction

  // s_top is S() of the nibble that lands on [79:76] after the rotation,
  // i.e. S(k[18:15]), computed by the shared key S-box outside this function.
  function automatic logic [79:0] key_update(input logic [79:0] k,
                                             input logic [3:0]  s_top,
                                             input logic [4:0]  rnd);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = s_top;
    r[19:15]   = r[19:15] ^ rnd;
    return r;
  endfunction

endpackage

// File: rtl/present_sbox.sv
// Single 4-bit PRESENT S-box, purely combinational.
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  assign o_y = sbox4(i_x);

endmodule

// File: rtl/present_sbox_parallel_64bit.sv
// PRESENT substitution layer: 16 S-boxes, nibble i on bits [4i+3:4i].
module present_sbox_parallel_64bit (
  input  logic [63:0] i_x,
  output logic [63:0] o_y
);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    present_sbox u_sbox (
      .i_x (i_x[4*g+3:4*g]),
      .o_y (o_y[4*g+3:4*g])
    );
  end

endmodule

// File: rtl/present80_round_ctrl.sv
// Round-serial PRESENT-80 encryption controller: one round plus one key
// schedule step per clock, with valid/ready handshakes on input and output.
module present80_round_ctrl #(
  parameter int ROUNDS = present_pkg::ROUNDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_pt,
  input  logic [79:0] i_in_key,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_ct,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  import present_pkg::*;

  localparam logic [4:0] LP_LAST_RND = 5'(ROUNDS);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high. Input side: in_ready is high only in IDLE, pt/key are
  // sampled on that edge only. Output side: out_valid/out_ct hold until
  // out_ready is seen; the transfer edge returns the controller to IDLE.

  ctrl_state_e r_fsm;
  ctrl_state_e w_fsm_nxt;
  logic [63:0] r_state;
  logic [79:0] r_key;
  logic [4:0]  r_rnd;

  logic [63:0] w_round_key;
  logic [63:0] w_sbox_in;
  logic [63:0] w_sbox_out;
  logic [3:0]  w_key_sbox_out;

  assign w_round_key = r_key[79:16];
  assign w_sbox_in   = r_state ^ w_round_key;

  present_sbox_parallel_64bit u_state_sbox (
    .i_x (w_sbox_in),
    .o_y (w_sbox_out)
  );

  // Nibble that the 61-bit left rotation places at [79:76].
  present_sbox u_key_sbox (
    .i_x (r_key[18:15]),
    .o_y (w_key_sbox_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE: if (i_in_valid) w_fsm_nxt = RUN;
      RUN:  if (r_rnd == LP_LAST_RND) w_fsm_nxt = DONE;
      DONE: if (i_out_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (i_in_valid) begin
            r_state <= i_in_pt;
            r_key   <= i_in_key;
            r_rnd   <= 5'd1;
          end
        end
        RUN: begin
          r_state <= p_layer(w_sbox_out);
          r_key   <= key_update(r_key, w_key_sbox_out, r_rnd);
          // Leave the counter at its last value rather than wrapping.
          if (r_rnd != LP_LAST_RND) r_rnd <= r_rnd + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_fsm == IDLE);
  assign o_busy      = (r_fsm == RUN);
  assign o_out_valid = (r_fsm == DONE);
  // Final whitening with K32; forced to zero outside DONE.
  assign o_out_ct    = (r_fsm == DONE) ? w_sbox_in : 64'd0;
  assign o_dbg_state = r_fsm;

endmodule

// File: tb/tb_present80_round_ctrl.sv
// Directed bench for present80_round_ctrl: known-answer vectors plus
// output back-pressure, mid-run reset and input-noise sequences.
module tb_present80_round_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] i_in_pt;
  logic [79:0] i_in_key;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_out_ct;
  logic        o_busy;
  logic [1:0]  o_dbg_state;

  int checks;
  int errors;

  typedef struct {
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
  } vec_t;

  vec_t vecs[4];

  present80_round_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_pt     (i_in_pt),
    .i_in_key    (i_in_key),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_ct    (o_out_ct),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    logic [95:0] rnd_key;
    rnd_key    = {$urandom, $urandom, $urandom};
    i_in_valid = 1'($urandom_range(0, 1));
    i_in_pt    = {$urandom, $urandom};
    i_in_key   = rnd_key[79:0];
  endtask

  // Offer one block and let the accepting edge happen.
  task automatic accept(input logic [63:0] pt, input logic [79:0] key);
    int n;
    n = 0;
    while (!o_in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", 80'(o_in_ready), 80'd1);
    i_in_valid = 1'b1;
    i_in_pt    = pt;
    i_in_key   = key;
    tick();
    i_in_valid = 1'b0;
    i_in_pt    = {$urandom, $urandom};
    i_in_key   = {16'h0, $urandom, $urandom};
    check("run_busy", 80'(o_busy), 80'd1);
    check("run_in_ready", 80'(o_in_ready), 80'd0);
  endtask

  // Wait for the result, check latency and ciphertext, then hand it off.
  task automatic finish_block(input logic [63:0] exp_ct, input bit noise, input string name);
    int cyc;
    cyc = 0;
    while (!o_out_valid && cyc < 100) begin
      if (noise) drive_noise();
      tick();
      cyc++;
    end
    i_in_valid = 1'b0;
    check({name, "_latency"}, 80'(cyc), 80'd31);
    check({name, "_ct"}, 80'(o_out_ct), 80'(exp_ct));
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    check({name, "_out_valid_drop"}, 80'(o_out_valid), 80'd0);
    check({name, "_in_ready_back"}, 80'(o_in_ready), 80'd1);
  endtask

  initial begin
    logic [63:0] held_exp;
    int          cyc;

    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_pt     = '0;
    i_in_key    = '0;
    i_out_ready = 1'b0;

    vecs[0] = '{pt: 64'h0000000000000000, key: 80'h00000000000000000000, ct: 64'h5579C1387B228445};
    vecs[1] = '{pt: 64'h0000000000000000, key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'hE72C46C0F5945049};
    vecs[2] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'h00000000000000000000, ct: 64'hA112FFC72F68417B};
    vecs[3] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'h3333DCD3213210D2};

    #12;
    check("rst_in_ready", 80'(o_in_ready), 80'd1);
    check("rst_out_valid", 80'(o_out_valid), 80'd0);
    check("rst_busy", 80'(o_busy), 80'd0);
    check("rst_out_ct", 80'(o_out_ct), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Known-answer vectors
    for (int i = 0; i < 4; i++) begin
      accept(vecs[i].pt, vecs[i].key);
      finish_block(vecs[i].ct, 1'b0, $sformatf("kat%0d", i));
    end

    // Back-pressure in DONE with a competing in_valid
    accept(vecs[0].pt, vecs[0].key);
    cyc = 0;
    while (!o_out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("hold_latency", 80'(cyc), 80'd31);
    held_exp = vecs[0].ct;
    for (int i = 0; i < 10; i++) begin
      i_in_valid = 1'b1;
      i_in_pt    = {$urandom, $urandom};
      i_in_key   = {16'hA5A5, $urandom, $urandom};
      tick();
      check("hold_ct", 80'(o_out_ct), 80'(held_exp));
      check("hold_out_valid", 80'(o_out_valid), 80'd1);
      check("hold_in_ready", 80'(o_in_ready), 80'd0);
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    check("hold_release_idle", 80'(o_in_ready), 80'd1);
    check("hold_release_valid", 80'(o_out_valid), 80'd0);
    accept(vecs[3].pt, vecs[3].key);
    finish_block(vecs[3].ct, 1'b0, "after_hold");

    // Reset in the middle of the round sequence
    accept(vecs[2].pt, vecs[2].key);
    repeat (14) tick();
    check("mid_busy", 80'(o_busy), 80'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 80'(o_in_ready), 80'd1);
    check("midrst_out_valid", 80'(o_out_valid), 80'd0);
    check("midrst_busy", 80'(o_busy), 80'd0);
    check("midrst_out_ct", 80'(o_out_ct), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    accept(vecs[1].pt, vecs[1].key);
    finish_block(vecs[1].ct, 1'b0, "after_rst");

    // Input noise during RUN must not disturb the sampled block
    accept(vecs[2].pt, vecs[2].key);
    finish_block(vecs[2].ct, 1'b1, "noise");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
